// File: rtl/wb_cdb_arbiter.sv
// wb_cdb_arbiter: round-robin writeback arbiter onto a registered single-issue CDB, stale epochs absorbed; WB_ARB_STATS_EN adds drop/stall counters
`ifndef ROB_W
`define ROB_W 6
`endif
`ifndef PHYS_W
`define PHYS_W 7
`endif
module wb_cdb_arbiter #(
  parameter int NUM_PORTS = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic [1:0]                          cur_epoch,
  input  logic [NUM_PORTS-1:0]                wb_valid,
  output logic [NUM_PORTS-1:0]                wb_ready,
  input  logic [NUM_PORTS-1:0][31:0]          wb_pc,
  input  logic [NUM_PORTS-1:0]                wb_uses_rd,
  input  logic [NUM_PORTS-1:0][`ROB_W-1:0]    wb_rob_idx,
  input  logic [NUM_PORTS-1:0][`PHYS_W-1:0]   wb_prd_new,
  input  logic [NUM_PORTS-1:0][1:0]           wb_epoch,
  input  logic [NUM_PORTS-1:0][31:0]          wb_data,
  output logic                                cdb_valid,
  output logic                                cdb_wake_valid,
  output logic [31:0]                         cdb_pc,
  output logic                                cdb_uses_rd,
  output logic [`ROB_W-1:0]                   cdb_rob_idx,
  output logic [`PHYS_W-1:0]                  cdb_prd_new,
  output logic [31:0]                         cdb_data,
  output logic [15:0]                         stat_drop_cnt,
  output logic [15:0]                         stat_stall_cnt
);
  localparam int PW = $clog2(NUM_PORTS);
  logic [PW-1:0]        r_rr;
  logic [NUM_PORTS-1:0] w_live, w_stale, w_grant_oh;
  logic                 w_grant;
  logic [PW-1:0]        w_gidx;
  int                   w_idx;
  // classify each valid port as live (current epoch, no flush) or stale
  always_comb begin
    w_live = '0;
    w_stale = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_live[i] = wb_valid[i] && wb_epoch[i] == cur_epoch && !flush;
      w_stale[i] = wb_valid[i] && !w_live[i];
    end
  end
  // scan from the pointer backwards so the last hit is the first live port in round-robin order
  always_comb begin
    w_grant = 1'b0;
    w_gidx = '0;
    w_idx = 0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      w_idx = int'(r_rr) + k;
      w_idx = w_idx >= NUM_PORTS ? w_idx - NUM_PORTS : w_idx;
      if (w_live[PW'(w_idx)]) begin
        w_grant = 1'b1;
        w_gidx = PW'(w_idx);
      end
    end
  end
  assign w_grant_oh = w_grant ? NUM_PORTS'(1) << w_gidx : '0;
  assign wb_ready = rst ? '0 : (w_stale | w_grant_oh);
  assign cdb_wake_valid = cdb_valid && cdb_uses_rd;
  // load the grantee onto the CDB for one cycle and advance the pointer past it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr <= '0;
      cdb_valid <= 1'b0;
      cdb_pc <= '0;
      cdb_uses_rd <= 1'b0;
      cdb_rob_idx <= '0;
      cdb_prd_new <= '0;
      cdb_data <= '0;
    end else begin
      cdb_valid <= w_grant;
      if (w_grant) begin
        r_rr <= w_gidx == PW'(NUM_PORTS - 1) ? '0 : w_gidx + 1'b1;
        cdb_pc <= wb_pc[w_gidx];
        cdb_uses_rd <= wb_uses_rd[w_gidx];
        cdb_rob_idx <= wb_rob_idx[w_gidx];
        cdb_prd_new <= wb_prd_new[w_gidx];
        cdb_data <= wb_data[w_gidx];
      end
    end
  end
`ifdef WB_ARB_STATS_EN
  logic [15:0] r_drop, r_stall;
  logic [16:0] w_drop_sum;
  logic        w_stall;
  assign w_drop_sum = {1'b0, r_drop} + 17'($countones(w_stale));
  assign w_stall = |(w_live & ~w_grant_oh);
  // saturating counters of dropped stale results and contention-stall cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop <= '0;
      r_stall <= '0;
    end else begin
      r_drop <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      r_stall <= (w_stall && r_stall != 16'hFFFF) ? r_stall + 16'd1 : r_stall;
    end
  end
  assign stat_drop_cnt = r_drop;
  assign stat_stall_cnt = r_stall;
`else
  assign stat_drop_cnt = '0;
  assign stat_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_wb_cdb_arbiter.sv
// tb_wb_cdb_arbiter: directed self-checking bench for wb_cdb_arbiter
`ifndef ROB_W
`define ROB_W 6
`endif
`ifndef PHYS_W
`define PHYS_W 7
`endif
module tb_wb_cdb_arbiter;
  localparam int N = 3;
`ifdef WB_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic                        clk = 1'b0;
  logic                        rst, flush;
  logic [1:0]                  cur_epoch;
  logic [N-1:0]                wb_valid, wb_ready, wb_uses_rd;
  logic [N-1:0][31:0]          wb_pc, wb_data;
  logic [N-1:0][`ROB_W-1:0]    wb_rob_idx;
  logic [N-1:0][`PHYS_W-1:0]   wb_prd_new;
  logic [N-1:0][1:0]           wb_epoch;
  logic                        cdb_valid, cdb_wake_valid, cdb_uses_rd;
  logic [31:0]                 cdb_pc, cdb_data;
  logic [`ROB_W-1:0]           cdb_rob_idx;
  logic [`PHYS_W-1:0]          cdb_prd_new;
  logic [15:0]                 stat_drop_cnt, stat_stall_cnt;
  int                          n_chk = 0, n_err = 0;
  wb_cdb_arbiter #(.NUM_PORTS(N)) dut (
    .clk(clk), .rst(rst), .flush(flush), .cur_epoch(cur_epoch),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_pc(wb_pc), .wb_uses_rd(wb_uses_rd),
    .wb_rob_idx(wb_rob_idx), .wb_prd_new(wb_prd_new), .wb_epoch(wb_epoch), .wb_data(wb_data),
    .cdb_valid(cdb_valid), .cdb_wake_valid(cdb_wake_valid), .cdb_pc(cdb_pc),
    .cdb_uses_rd(cdb_uses_rd), .cdb_rob_idx(cdb_rob_idx), .cdb_prd_new(cdb_prd_new),
    .cdb_data(cdb_data), .stat_drop_cnt(stat_drop_cnt), .stat_stall_cnt(stat_stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    flush = 1'b0;
    cur_epoch = 2'd1;
    wb_valid = 3'b111;
    wb_uses_rd = 3'b111;
    for (int i = 0; i < N; i++) begin
      wb_pc[i] = 32'h1000 + 32'(i * 4);
      wb_data[i] = 32'hA0 + 32'(i);
      wb_rob_idx[i] = `ROB_W'(10 + i);
      wb_prd_new[i] = `PHYS_W'(20 + i);
      wb_epoch[i] = 2'd1;
    end
    tick();
    chk("rst_ready", wb_ready, 3'b000);
    chk("rst_cdb_valid", cdb_valid, 0);
    chk("rst_wake", cdb_wake_valid, 0);
    chk("rst_data", cdb_data, 0);
    chk("rst_rob", cdb_rob_idx, 0);
    chk("rst_drop", stat_drop_cnt, 0);
    chk("rst_stall", stat_stall_cnt, 0);
    rst = 1'b0;
    #1;
    chk("cont_ready0", wb_ready, 3'b001);
    tick();
    chk("cont_v0", cdb_valid, 1);
    chk("cont_d0", cdb_data, 32'hA0);
    chk("cont_ready1", wb_ready, 3'b010);
    tick();
    chk("cont_v1", cdb_valid, 1);
    chk("cont_d1", cdb_data, 32'hA1);
    chk("cont_rob1", cdb_rob_idx, 11);
    chk("cont_ready2", wb_ready, 3'b100);
    tick();
    chk("cont_v2", cdb_valid, 1);
    chk("cont_d2", cdb_data, 32'hA2);
    chk("cont_prd2", cdb_prd_new, 22);
    chk("cont_ready3", wb_ready, 3'b001);
    chk("cont_stall", stat_stall_cnt, STATS ? 3 : 0);
    tick();
    chk("cont_v3", cdb_valid, 1);
    chk("cont_d3", cdb_data, 32'hA0);
    wb_valid = 3'b000;
    tick();
    chk("cont_idle", cdb_valid, 0);
    wb_valid = 3'b001;
    wb_data[0] = 32'h1234;
    wb_rob_idx[0] = `ROB_W'(5);
    wb_prd_new[0] = `PHYS_W'(9);
    wb_pc[0] = 32'h100;
    #1;
    chk("single_ready", wb_ready, 3'b001);
    tick();
    wb_valid = 3'b000;
    chk("single_v", cdb_valid, 1);
    chk("single_data", cdb_data, 32'h1234);
    chk("single_rob", cdb_rob_idx, 5);
    chk("single_prd", cdb_prd_new, 9);
    chk("single_pc", cdb_pc, 32'h100);
    chk("single_wake", cdb_wake_valid, 1);
    tick();
    chk("single_done", cdb_valid, 0);
    wb_valid = 3'b010;
    wb_uses_rd[1] = 1'b0;
    wb_data[1] = 32'h55;
    #1;
    chk("nord_ready", wb_ready, 3'b010);
    tick();
    wb_valid = 3'b000;
    chk("nord_v", cdb_valid, 1);
    chk("nord_wake", cdb_wake_valid, 0);
    chk("nord_data", cdb_data, 32'h55);
    wb_uses_rd[1] = 1'b1;
    cur_epoch = 2'd2;
    wb_epoch[1] = 2'd0;
    wb_epoch[2] = 2'd2;
    wb_data[1] = 32'h66;
    wb_data[2] = 32'h77;
    wb_valid = 3'b110;
    #1;
    chk("stale_ready", wb_ready, 3'b110);
    tick();
    wb_valid = 3'b000;
    chk("stale_v", cdb_valid, 1);
    chk("stale_data", cdb_data, 32'h77);
    chk("stale_drop", stat_drop_cnt, STATS ? 1 : 0);
    wb_epoch = {2'd2, 2'd2, 2'd2};
    wb_data[0] = 32'h88;
    wb_valid = 3'b001;
    #1;
    chk("flush_t_ready", wb_ready, 3'b001);
    tick();
    flush = 1'b1;
    wb_valid = 3'b011;
    #1;
    chk("flush_ready", wb_ready, 3'b011);
    chk("flush_bcast_v", cdb_valid, 1);
    chk("flush_bcast_d", cdb_data, 32'h88);
    tick();
    flush = 1'b0;
    wb_valid = 3'b000;
    chk("flush_after", cdb_valid, 0);
    chk("flush_drop", stat_drop_cnt, STATS ? 3 : 0);
    wb_valid = 3'b010;
    tick();
    wb_valid = 3'b000;
    chk("rstb_v", cdb_valid, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("rstb_async_v", cdb_valid, 0);
    chk("rstb_async_d", cdb_data, 0);
    chk("rstb_drop", stat_drop_cnt, 0);
    tick();
    rst = 1'b0;
    wb_valid = 3'b111;
    #1;
    chk("rstb_ready", wb_ready, 3'b001);
    tick();
    wb_valid = 3'b000;
    chk("rstb_grant_d", cdb_data, 32'h88);
    chk("rstb_grant_v", cdb_valid, 1);
    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
